// File: rtl/key_sched_ctrl.sv
// rtl/key_sched_ctrl.sv - AES-128 key schedule sequencer driving an iterative keyexpansion core
//
// Loads a cipher key on start, steps the external keyexpansion core ten times
// and stores round keys 0..10 in an 11-entry buffer with a registered read port.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle request, honoured only in IDLE
//   key_in       128-bit cipher key, sampled with start
//   busy         high while the expansion steps are running
//   done         one-cycle pulse once all 11 round keys are stored
//   keys_valid   level, buffer holds a complete schedule
//   rk_addr      round-key read index 0..10
//   rk_data      round key at rk_addr, one cycle latency, zero for index > 10
//   kx_key       key word to keyexpansion
//   kx_nr        round counter to keyexpansion
//   kx_flag      flag to keyexpansion
//   kx_count     count to keyexpansion, cycles 1,2,3
//   kx_keyround  fed-back key word from keyexpansion
//   kx_keyout    round key produced by keyexpansion

module key_sched_ctrl #(
   parameter int KX_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   input  logic [3:0]   rk_addr,
   output logic [127:0] rk_data,
   output logic [255:0] kx_key,
   output logic [3:0]   kx_nr,
   output logic         kx_flag,
   output logic [1:0]   kx_count,
   input  logic [255:0] kx_keyround,
   input  logic [127:0] kx_keyout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   // Wait counter value on the edge where the core output is valid.
   localparam logic [2:0] LAT_M1 = 3'(KX_LAT - 1);

   state_t         state_q, state_d;
   logic [2:0]     wait_q, wait_d;
   logic [255:0]   kx_key_q, kx_key_d;
   logic [3:0]     kx_nr_q, kx_nr_d;
   logic           kx_flag_q, kx_flag_d;
   logic [1:0]     kx_count_q, kx_count_d;
   logic           keys_valid_q, keys_valid_d;
   logic [127:0]   rk_data_q, rk_data_d;

   // Round-key buffer is deliberately left out of reset.
   logic [127:0]   rk_q [0:10];
   logic           rk_we;
   logic [3:0]     rk_waddr;
   logic [127:0]   rk_wdata;

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      kx_key_d     = kx_key_q;
      kx_nr_d      = kx_nr_q;
      kx_flag_d    = kx_flag_q;
      kx_count_d   = kx_count_q;
      keys_valid_d = keys_valid_q;
      rk_we        = 1'b0;
      rk_waddr     = kx_nr_q;
      rk_wdata     = kx_keyout;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = STEP;
               rk_we        = 1'b1;
               rk_waddr     = 4'd0;
               rk_wdata     = key_in;
               kx_key_d     = {key_in, 128'h0};
               kx_nr_d      = 4'd1;
               kx_flag_d    = 1'b0;
               kx_count_d   = 2'd1;
               wait_d       = 3'd0;
               keys_valid_d = 1'b0;
            end
         end
         STEP: begin
            if (wait_q == LAT_M1) begin
               rk_we = 1'b1;
               if (kx_nr_q == 4'd10) begin
                  state_d      = DONE;
                  keys_valid_d = 1'b1;
               end else begin
                  // Flag alternates with the parity of the round just finished.
                  kx_flag_d  = kx_nr_q[0];
                  kx_count_d = (kx_count_q == 2'd3) ? 2'd1 : kx_count_q + 2'd1;
                  kx_nr_d    = kx_nr_q + 4'd1;
                  kx_key_d   = kx_keyround;
                  wait_d     = 3'd0;
               end
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rk_data_d = (rk_addr <= 4'd10) ? rk_q[rk_addr] : 128'h0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_q       <= 3'd0;
         kx_key_q     <= 256'h0;
         kx_nr_q      <= 4'd0;
         kx_flag_q    <= 1'b0;
         kx_count_q   <= 2'd0;
         keys_valid_q <= 1'b0;
         rk_data_q    <= 128'h0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         kx_key_q     <= kx_key_d;
         kx_nr_q      <= kx_nr_d;
         kx_flag_q    <= kx_flag_d;
         kx_count_q   <= kx_count_d;
         keys_valid_q <= keys_valid_d;
         rk_data_q    <= rk_data_d;
      end
   end

   // A write and a read of the same index on one edge returns the old entry.
   always_ff @(posedge clk) begin
      if (rk_we && !rst && (rk_waddr <= 4'd10)) begin
         rk_q[rk_waddr] <= rk_wdata;
      end
   end

   assign busy       = (state_q == STEP);
   assign done       = (state_q == DONE);
   assign keys_valid = keys_valid_q;
   assign rk_data    = rk_data_q;
   assign kx_key     = kx_key_q;
   assign kx_nr      = kx_nr_q;
   assign kx_flag    = kx_flag_q;
   assign kx_count   = kx_count_q;

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequencer that drives the iterative `keyexpansion` core for AES-128 and turns its per-step output into a stored set of round keys.

- On a start request it loads the cipher key, then steps `keyexpansion` ten times, supplying `Nr`, `flag`, `count` and the fed-back key word.
- It captures round keys 0..10 into an 11-entry buffer.
- It sits between the key input and the cipher round datapath, which reads round keys through a registered read port.

## Interface
Parameters:
- KX_LAT, 1, clock cycles from a change on `kx_*` outputs to valid `kx_keyround`/`kx_keyout`; legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- key_in  in  128  cipher key; sampled with start.
- busy  out  1  high while expansion is in progress (states STEP, DONE excluded).
- done  out  1  one-cycle pulse when all 11 round keys are stored.
- keys_valid  out  1  level; high while the buffer holds a complete schedule.
- rk_addr  in  4  round-key index 0..10.
- rk_data  out  128  round key at rk_addr; registered, 1-cycle latency.
- kx_key  out  256  key word to `keyexpansion`; initial key occupies bits [255:128], with [127:0] zero.
- kx_nr  out  4  round counter to `keyexpansion`.
- kx_flag  out  1  flag to `keyexpansion`.
- kx_count  out  2  count to `keyexpansion`; cycles 1,2,3.
- kx_keyround  in  256  fed-back key word from `keyexpansion`.
- kx_keyout  in  128  round key produced by `keyexpansion`.

## Operation
States:
- IDLE → STEP on start (captured in IDLE).
- STEP → STEP after each capture while nr<10.
- STEP → DONE on the capture with nr=10.
- DONE → IDLE unconditionally.

Start edge (IDLE, start=1):
- rk[0] ← key_in.
- kx_key ← {key_in, 128'h0}; kx_nr ← 1; kx_flag ← 0; kx_count ← 1.
- wait counter ← 0; keys_valid ← 0; busy ← 1.

STEP:
- The wait counter increments each cycle.
- On the edge where it equals KX_LAT-1 (capture edge):
  - rk[kx_nr] ← kx_keyout.
  - If kx_nr=10 → DONE.
  - Otherwise, in parallel:
    - kx_flag ← kx_nr[0] (old value);
    - kx_count ← (kx_count==3) ? 1 : kx_count+1;
    - kx_nr ← kx_nr+1;
    - kx_key ← kx_keyround;
    - counter ← 0.

DONE:
- done=1 and keys_valid=1 for exactly this cycle's output.
- busy=0.
- Next edge → IDLE.

Rules:
- kx_* outputs hold stable between capture edges.
- kx_count never takes the value 0 or 3→3; sequence from start: (nr,flag,count) = (1,0,1),(2,1,2),(3,0,3),(4,1,1),(5,0,2),…,(10,1,1).
- start while not in IDLE is ignored; no queuing.
- start in IDLE while keys_valid=1 clears keys_valid on that edge; a new schedule overwrites rk[].
- The read port works in every state and returns the current buffer content (may be mixed during STEP).
- rk_addr > 10 returns 128'h0.

## Timing
Reset values:
- State IDLE; busy=0, done=0, keys_valid=0, rk_data=0.
- kx_key=0, kx_nr=0, kx_flag=0, kx_count=0.
- Counter 0; buffer contents are not reset.

Latency:
- start edge E0; captures at E0+k·KX_LAT for k=1..10.
- done high in the cycle after E0+10·KX_LAT (KX_LAT=1: done visible after edge E10).
- busy high from after E0 through after E0+10·KX_LAT−1.

Other timing rules:
- rk_data updates on the edge after rk_addr changes.
- Simultaneous buffer write and read of the same index returns the old value.
- rst asserted at any edge, including mid-STEP or DONE, forces reset values on that edge; done does not pulse, and keys_valid stays 0 until a full new schedule completes.
- start coincident with rst is ignored.

## Test plan
- FIPS-197 key: start with key_in=2b7e151628aed2a6abf7158809cf4f3c, KX_LAT=1, real `keyexpansion` attached.
  - done pulses after edge E10.
  - rk[0] reads 2b7e151628aed2a6abf7158809cf4f3c.
  - rk[1] reads a0fafe1788542cb123a339392a6c7605.
  - rk[10] reads d014f9a8c9ee2589e13f0cc8b6630ca6.
- Control sequence: monitor (kx_nr, kx_flag, kx_count) at each capture edge → exactly (1,0,1),(2,1,2),(3,0,3),(4,1,1)…(10,1,1); kx_key after each capture equals the previous kx_keyround.
- Latency parameter: KX_LAT=3 with a delayed stub core → captures at E3, E6…E30; done after E30; kx_* stable across each 3-cycle window.
- Ignored start: pulse start at E4 while busy → no restart, schedule completes unchanged, and exactly one done pulse.
- Reset mid-operation: rst at E5 → busy=0, keys_valid=0, kx_nr=0, and no done pulse. A fresh start then completes normally.
- Read port edge cases: rk_addr=11 → rk_data=0 next cycle. A new start after completion drops keys_valid on the start edge and raises it again only with the new done.
